// File: rtl/event_encoder_8to3.sv
// Sequential 8-to-3 event encoder: captures strobes into a pending set and
// emits their codes one per accept, bit 7 (code 0) first.
module event_encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       coalesce
);

    // Handshake: code is consumed on any edge where valid && ready; valid may
    // rise without ready, never falls without an accept, and code is frozen
    // while valid && !ready.

    logic [7:0] cand;
    logic       load;
    logic [2:0] sel_idx;
    logic [7:0] sel_mask;
    logic [2:0] code_next;
    logic       valid_next;
    logic [7:0] pending_next;
    logic       coalesce_next;

    assign cand = pending | (en ? req : 8'h00);
    assign load = (!valid || ready) && (cand != 8'h00);

    // Ascending scan so the highest set bit is the one left in sel_idx.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    assign sel_mask = 8'h01 << sel_idx;

    always_comb begin
        code_next     = code;
        valid_next    = valid;
        pending_next  = cand;
        coalesce_next = en && ((pending & req) != 8'h00);
        if (load) begin
            code_next    = 3'd7 - sel_idx;
            valid_next   = 1'b1;
            pending_next = cand & ~sel_mask;
        end else if (valid && ready) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code     <= 3'b000;
            valid    <= 1'b0;
            pending  <= 8'h00;
            coalesce <= 1'b0;
        end else begin
            code     <= code_next;
            valid    <= valid_next;
            pending  <= pending_next;
            coalesce <= coalesce_next;
        end
    end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed, table-driven bench for event_encoder_8to3 with a few hand-written
// sequences for reset-mid-drain and back-pressured draining.
module tb_event_encoder_8to3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       coalesce;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       ready;
        logic       ev;
        logic [2:0] ec;
        logic [7:0] ep;
        logic       eco;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];

    event_encoder_8to3 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .coalesce (coalesce)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic [7:0] q,
                       input logic rd, input logic ev, input logic [2:0] ec,
                       input logic [7:0] ep, input logic eco);
        vec_t v;
        v.rst = r; v.en = e; v.req = q; v.ready = rd;
        v.ev = ev; v.ec = ec; v.ep = ep; v.eco = eco;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q,
                        input logic rd);
        rst = r; en = e; req = q; ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int row, input logic ev, input logic [2:0] ec,
                           input logic [7:0] ep, input logic eco);
        chk("valid",    row, {7'd0, valid},    {7'd0, ev});
        chk("code",     row, {5'd0, code},     {5'd0, ec});
        chk("pending",  row, pending,          ep);
        chk("coalesce", row, {7'd0, coalesce}, {7'd0, eco});
    endtask

    initial begin
        logic [7:0] decoded;
        rst = 1'b1; en = 1'b1; req = 8'hFF; ready = 1'b1;

        // reset held with all strobes high
        add(1,1,8'hFF,1, 0,3'd0,8'h00,0);
        add(1,1,8'hFF,1, 0,3'd0,8'h00,0);
        add(1,1,8'hFF,0, 0,3'd0,8'h00,0);
        // idle after release
        add(0,1,8'h00,1, 0,3'd0,8'h00,0);
        add(0,1,8'h00,1, 0,3'd0,8'h00,0);
        // single event (row 5 decoded below)
        add(0,1,8'h20,1, 1,3'd2,8'h00,0);
        add(0,1,8'h00,1, 0,3'd2,8'h00,0);
        // burst A5 -> 0,2,5,7
        add(0,1,8'hA5,1, 1,3'd0,8'h25,0);
        add(0,1,8'h00,1, 1,3'd2,8'h05,0);
        add(0,1,8'h00,1, 1,3'd5,8'h01,0);
        add(0,1,8'h00,1, 1,3'd7,8'h00,0);
        add(0,1,8'h00,1, 0,3'd7,8'h00,0);
        // back-pressure and coalesce
        add(0,1,8'h81,0, 1,3'd0,8'h01,0);
        add(0,1,8'h00,0, 1,3'd0,8'h01,0);
        add(0,1,8'h01,0, 1,3'd0,8'h01,1);
        add(0,1,8'h00,0, 1,3'd0,8'h01,0);
        add(0,1,8'h00,1, 1,3'd7,8'h00,0);
        add(0,1,8'h00,1, 0,3'd7,8'h00,0);
        add(0,1,8'h00,1, 0,3'd7,8'h00,0);
        // enable gating
        add(0,0,8'hFF,1, 0,3'd7,8'h00,0);
        add(0,1,8'h02,1, 1,3'd6,8'h00,0);
        add(0,1,8'h00,1, 0,3'd6,8'h00,0);
        // in-flight line re-requested: re-queued, no coalesce
        add(0,1,8'h80,0, 1,3'd0,8'h00,0);
        add(0,1,8'h80,0, 1,3'd0,8'h80,0);
        add(0,1,8'h00,1, 1,3'd0,8'h00,0);
        add(0,1,8'h00,1, 0,3'd0,8'h00,0);
        // all 8 events at once
        add(0,1,8'hFF,1, 1,3'd0,8'h7F,0);
        add(0,1,8'h00,1, 1,3'd1,8'h3F,0);
        add(0,1,8'h00,1, 1,3'd2,8'h1F,0);
        add(0,1,8'h00,1, 1,3'd3,8'h0F,0);
        add(0,1,8'h00,1, 1,3'd4,8'h07,0);
        add(0,1,8'h00,1, 1,3'd5,8'h03,0);
        add(0,1,8'h00,1, 1,3'd6,8'h01,0);
        add(0,1,8'h00,1, 1,3'd7,8'h00,0);
        add(0,1,8'h00,1, 0,3'd7,8'h00,0);
        // pending full under back-pressure: only coalesce
        add(0,1,8'hFF,0, 1,3'd0,8'h7F,0);
        add(0,1,8'hFF,0, 1,3'd0,8'hFF,1);
        add(0,1,8'hFF,0, 1,3'd0,8'hFF,1);
        add(0,1,8'h00,0, 1,3'd0,8'hFF,0);
        add(0,1,8'h00,1, 1,3'd0,8'h7F,0);
        add(0,1,8'h00,1, 1,3'd1,8'h3F,0);
        add(0,1,8'h00,1, 1,3'd2,8'h1F,0);
        add(0,1,8'h00,1, 1,3'd3,8'h0F,0);
        add(0,1,8'h00,1, 1,3'd4,8'h07,0);
        add(0,1,8'h00,1, 1,3'd5,8'h03,0);
        add(0,1,8'h00,1, 1,3'd6,8'h01,0);
        add(0,1,8'h00,1, 1,3'd7,8'h00,0);
        add(0,1,8'h00,1, 0,3'd7,8'h00,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].ready);
            chk_all(i, vecs[i].ev, vecs[i].ec, vecs[i].ep, vecs[i].eco);
            if (i == 5) begin
                decoded = 8'h80 >> code;
                chk("decode", i, decoded, 8'h20);
            end
        end

        // reset mid-drain
        step(0, 1, 8'hF0, 0);
        chk_all(100, 1'b1, 3'd0, 8'h70, 1'b0);
        step(1, 1, 8'h00, 0);
        chk_all(101, 1'b0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'h00, 1);
            chk("no_stale_valid", 102 + i, {7'd0, valid}, 8'h00);
            chk("no_stale_pend",  102 + i, pending, 8'h00);
        end

        // fresh burst drained under intermittent back-pressure
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        step(0, 1, 8'h18, 0);
        for (int i = 0; i < 10; i++) begin
            rst = 1'b0; en = 1'b1; req = 8'h00;
            ready = (i % 3 != 0);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_code", 200 + i, {5'd0, code}, 8'hFF);
                end else begin
                    chk("sb_code", 200 + i, {5'd0, code}, {5'd0, exp_q.pop_front()});
                end
            end
            @(posedge clk);
            #1;
        end
        chk("sb_left", 300, 8'(exp_q.size()), 8'd0);
        chk("final_valid", 301, {7'd0, valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
